seq_checker: RTL and testbench

//  Downstream monitor for the sequence generator: consumes seq_o values and checks each against
//  n(x)=n(x-2)+n(x-3) (mod 2^32), with the first three terms checked against seed constants.

---
 rtl/seq_checker.sv | 144 ++++++++++++++
 tb/tb_seq_checker.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_checker.sv
// Monitor for the sequence generator: checks each accepted term against
// n(x) = n(x-2) + n(x-3) mod 2^32 and records match, counts, first failure and sum wrap.
module seq_checker #(
    parameter logic [31:0] SEED0 = 32'd0,
    parameter logic [31:0] SEED1 = 32'd1,
    parameter logic [31:0] SEED2 = 32'd1,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      seq_i,
    input  logic             seq_valid_i,
    output logic             chk_valid_o,
    output logic             match_o,
    output logic             error_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic [CNT_W-1:0] sample_cnt_o,
    output logic [CNT_W-1:0] err_idx_o,
    output logic [31:0]      err_exp_o,
    output logic [31:0]      err_got_o,
    output logic             wrap_o
);

    typedef enum logic [1:0] {StSeed0, StSeed1, StSeed2, StTrack} state_e;

    state_e           state_q, state_d;
    logic [31:0]      h1_q, h1_d, h2_q, h2_d, h3_q, h3_d;
    logic             chk_valid_q, chk_valid_d;
    logic             match_q, match_d;
    logic             error_q, error_d;
    logic             wrap_q, wrap_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
    logic [CNT_W-1:0] err_idx_q, err_idx_d;
    logic [31:0]      err_exp_q, err_exp_d;
    logic [31:0]      err_got_q, err_got_d;

    logic [32:0] sum;
    logic [31:0] expected;
    logic        mismatch;

    assign sum = {1'b0, h2_q} + {1'b0, h3_q};

    always_comb begin
        expected = sum[31:0];
        unique case (state_q)
            StSeed0: expected = SEED0;
            StSeed1: expected = SEED1;
            StSeed2: expected = SEED2;
            StTrack: expected = sum[31:0];
        endcase
    end

    assign mismatch = (seq_i != expected);

    always_comb begin
        state_d      = state_q;
        h1_d         = h1_q;
        h2_d         = h2_q;
        h3_d         = h3_q;
        chk_valid_d  = 1'b0;
        match_d      = match_q;
        error_d      = error_q;
        wrap_d       = wrap_q;
        err_cnt_d    = err_cnt_q;
        sample_cnt_d = sample_cnt_q;
        err_idx_d    = err_idx_q;
        err_exp_d    = err_exp_q;
        err_got_d    = err_got_q;

        if (seq_valid_i) begin
            unique case (state_q)
                StSeed0: state_d = StSeed1;
                StSeed1: state_d = StSeed2;
                StSeed2: state_d = StTrack;
                StTrack: state_d = StTrack;
            endcase
            // History follows the prediction, so a corrupt sample cannot poison later terms.
            h3_d         = h2_q;
            h2_d         = h1_q;
            h1_d         = expected;
            sample_cnt_d = sample_cnt_q + CNT_W'(1);
            chk_valid_d  = 1'b1;
            match_d      = !mismatch;
            if (mismatch) begin
                error_d = 1'b1;
                if (err_cnt_q != '1) begin
                    err_cnt_d = err_cnt_q + CNT_W'(1);
                end
                if (!error_q) begin
                    err_idx_d = sample_cnt_q;
                    err_exp_d = expected;
                    err_got_d = seq_i;
                end
            end
            if (state_q == StTrack && sum[32]) begin
                wrap_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StSeed0;
            h1_q         <= '0;
            h2_q         <= '0;
            h3_q         <= '0;
            chk_valid_q  <= 1'b0;
            match_q      <= 1'b0;
            error_q      <= 1'b0;
            wrap_q       <= 1'b0;
            err_cnt_q    <= '0;
            sample_cnt_q <= '0;
            err_idx_q    <= '0;
            err_exp_q    <= '0;
            err_got_q    <= '0;
        end else begin
            state_q      <= state_d;
            h1_q         <= h1_d;
            h2_q         <= h2_d;
            h3_q         <= h3_d;
            chk_valid_q  <= chk_valid_d;
            match_q      <= match_d;
            error_q      <= error_d;
            wrap_q       <= wrap_d;
            err_cnt_q    <= err_cnt_d;
            sample_cnt_q <= sample_cnt_d;
            err_idx_q    <= err_idx_d;
            err_exp_q    <= err_exp_d;
            err_got_q    <= err_got_d;
        end
    end

    assign chk_valid_o  = chk_valid_q;
    assign match_o      = match_q;
    assign error_o      = error_q;
    assign wrap_o       = wrap_q;
    assign err_cnt_o    = err_cnt_q;
    assign sample_cnt_o = sample_cnt_q;
    assign err_idx_o    = err_idx_q;
    assign err_exp_o    = err_exp_q;
    assign err_got_o    = err_got_q;

endmodule

// File: tb/tb_seq_checker.sv
// Directed bench for seq_checker: clean, corrupted and gapped streams, a long
// reference-model run for wrap detection, mid-stream reset and a narrow-counter instance.
module tb_seq_checker;

    logic        clk;
    logic        reset;
    logic [31:0] seq_i;
    logic        seq_valid;
    logic        chk_valid, match, error, wrap;
    logic [15:0] err_cnt, sample_cnt, err_idx;
    logic [31:0] err_exp, err_got;

    logic [31:0] seq2;
    logic        seq_valid2;
    logic        chk_valid2, match2, error2, wrap2;
    logic [1:0]  err_cnt2, sample_cnt2, err_idx2;
    logic [31:0] err_exp2, err_got2;

    int unsigned checks = 0;
    int unsigned errors = 0;

    seq_checker u_dut (
        .clk          (clk),
        .reset        (reset),
        .seq_i        (seq_i),
        .seq_valid_i  (seq_valid),
        .chk_valid_o  (chk_valid),
        .match_o      (match),
        .error_o      (error),
        .err_cnt_o    (err_cnt),
        .sample_cnt_o (sample_cnt),
        .err_idx_o    (err_idx),
        .err_exp_o    (err_exp),
        .err_got_o    (err_got),
        .wrap_o       (wrap)
    );

    seq_checker #(.CNT_W(2)) u_dut_narrow (
        .clk          (clk),
        .reset        (reset),
        .seq_i        (seq2),
        .seq_valid_i  (seq_valid2),
        .chk_valid_o  (chk_valid2),
        .match_o      (match2),
        .error_o      (error2),
        .err_cnt_o    (err_cnt2),
        .sample_cnt_o (sample_cnt2),
        .err_idx_o    (err_idx2),
        .err_exp_o    (err_exp2),
        .err_got_o    (err_got2),
        .wrap_o       (wrap2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic feed(input logic [31:0] v);
        seq_i     = v;
        seq_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        seq_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        seq_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    logic [31:0] t1 [12] = '{32'd0, 32'd1, 32'd1, 32'd1, 32'd2, 32'd2,
                             32'd3, 32'd4, 32'd5, 32'd7, 32'd9, 32'd12};
    logic [63:0] ref_t [201];
    logic [31:0] v;
    logic        wrap_exp;

    initial begin
        reset      = 1'b1;
        seq_i      = '0;
        seq_valid  = 1'b0;
        seq2       = '0;
        seq_valid2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_chk_valid", 64'(chk_valid), 64'd0);
        check("rst_match", 64'(match), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_err_cnt", 64'(err_cnt), 64'd0);
        check("rst_sample_cnt", 64'(sample_cnt), 64'd0);
        check("rst_wrap", 64'(wrap), 64'd0);
        reset = 1'b0;
        idle();
        check("idle_no_chk", 64'(chk_valid), 64'd0);

        // T1: clean stream back-to-back
        for (int i = 0; i < 12; i++) begin
            feed(t1[i]);
            check("t1_chk_valid", 64'(chk_valid), 64'd1);
            check("t1_match", 64'(match), 64'd1);
        end
        idle();
        check("t1_chk_low", 64'(chk_valid), 64'd0);
        check("t1_error", 64'(error), 64'd0);
        check("t1_sample_cnt", 64'(sample_cnt), 64'd12);
        check("t1_err_cnt", 64'(err_cnt), 64'd0);

        // T2: idx 8 corrupted 5 -> 6
        do_reset();
        for (int i = 0; i < 12; i++) begin
            v = (i == 8) ? 32'd6 : t1[i];
            feed(v);
            check("t2_match", 64'(match), (i == 8) ? 64'd0 : 64'd1);
        end
        idle();
        check("t2_error", 64'(error), 64'd1);
        check("t2_err_idx", 64'(err_idx), 64'd8);
        check("t2_err_exp", 64'(err_exp), 64'd5);
        check("t2_err_got", 64'(err_got), 64'd6);
        check("t2_err_cnt", 64'(err_cnt), 64'd1);

        // T3: gapped 1 on, 2 off
        do_reset();
        for (int i = 0; i < 12; i++) begin
            feed(t1[i]);
            check("t3_chk_valid", 64'(chk_valid), 64'd1);
            check("t3_match", 64'(match), 64'd1);
            idle();
            check("t3_gap1", 64'(chk_valid), 64'd0);
            idle();
            check("t3_gap2", 64'(chk_valid), 64'd0);
        end
        check("t3_sample_cnt", 64'(sample_cnt), 64'd12);
        check("t3_error", 64'(error), 64'd0);

        // T5: errors at idx 3 (got 7) and idx 6 (got 0)
        do_reset();
        for (int i = 0; i < 12; i++) begin
            v = (i == 3) ? 32'd7 : (i == 6) ? 32'd0 : t1[i];
            feed(v);
            check("t5_match", 64'(match), (i == 3 || i == 6) ? 64'd0 : 64'd1);
        end
        idle();
        check("t5_err_cnt", 64'(err_cnt), 64'd2);
        check("t5_err_idx", 64'(err_idx), 64'd3);
        check("t5_err_exp", 64'(err_exp), 64'd1);
        check("t5_err_got", 64'(err_got), 64'd7);

        // T4: 200 terms from a 64-bit reference; wrap_o tracks first true term >= 2^32
        ref_t[0] = 64'd0;
        ref_t[1] = 64'd1;
        ref_t[2] = 64'd1;
        for (int i = 3; i < 201; i++) ref_t[i] = ref_t[i-2] + ref_t[i-3];
        do_reset();
        wrap_exp = 1'b0;
        for (int i = 0; i < 200; i++) begin
            // Before 64-bit overflow (~term 158) the flag is already sticky.
            if (i >= 3 && ref_t[i] >= 64'h1_0000_0000) wrap_exp = 1'b1;
            feed(ref_t[i][31:0]);
            check("t4_match", 64'(match), 64'd1);
            check("t4_wrap", 64'(wrap), 64'(wrap_exp));
        end
        check("t4_error", 64'(error), 64'd0);
        check("t4_wrap_final", 64'(wrap), 64'd1);

        // T6: error in TRACK, then reset with valid high
        feed(ref_t[200][31:0] + 32'd1);
        check("t6_pre_mismatch", 64'(match), 64'd0);
        check("t6_pre_error", 64'(error), 64'd1);
        reset     = 1'b1;
        seq_i     = 32'd5;
        seq_valid = 1'b1;
        @(posedge clk);
        #1;
        check("t6_chk_valid", 64'(chk_valid), 64'd0);
        check("t6_match", 64'(match), 64'd0);
        check("t6_error", 64'(error), 64'd0);
        check("t6_err_cnt", 64'(err_cnt), 64'd0);
        check("t6_sample_cnt", 64'(sample_cnt), 64'd0);
        check("t6_err_idx", 64'(err_idx), 64'd0);
        check("t6_err_exp", 64'(err_exp), 64'd0);
        check("t6_err_got", 64'(err_got), 64'd0);
        check("t6_wrap", 64'(wrap), 64'd0);
        reset = 1'b0;
        feed(32'd0);
        check("t6_seed0_chk", 64'(chk_valid), 64'd1);
        check("t6_seed0_match", 64'(match), 64'd1);
        check("t6_seed0_cnt", 64'(sample_cnt), 64'd1);
        idle();

        // CNT_W=2: five mismatches saturate err_cnt at 3, sample_cnt wraps to 1
        do_reset();
        seq2       = 32'd99;
        seq_valid2 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("n_match", 64'(match2), 64'd0);
        end
        seq_valid2 = 1'b0;
        @(posedge clk);
        #1;
        check("n_err_cnt", 64'(err_cnt2), 64'd3);
        check("n_sample_cnt", 64'(sample_cnt2), 64'd1);
        check("n_error", 64'(error2), 64'd1);
        check("n_err_idx", 64'(err_idx2), 64'd0);
        check("n_err_exp", 64'(err_exp2), 64'd0);
        check("n_err_got", 64'(err_got2), 64'd99);
        check("n_wrap", 64'(wrap2), 64'd0);
        check("n_chk_low", 64'(chk_valid2), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
